montgomery_mul_serial: RTL and testbench



---
 rtl/mont_pkg.sv | 16 +
 rtl/mont_step.sv | 26 ++
 rtl/montgomery_mul_serial.sv | 97 +++++++++
 tb/tb_montgomery_mul_serial.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and FSM encoding for the bit-serial Montgomery multiplier.
package mont_pkg;

  localparam int DEFAULT_WIDTH = 512;
  // Accumulator headroom: C stays below 2M and C + B + M stays below 4M.
  localparam int ACC_PAD       = 2;
  localparam int DEFAULT_ACC_W = DEFAULT_WIDTH + ACC_PAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery step: C' = (C + a_i*B [+ M if odd]) / 2. Purely combinational.
module mont_step
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+ACC_PAD-1:0] c,
  input  logic                     a_i,
  input  logic [WIDTH-1:0]         b,
  input  logic [WIDTH-1:0]         m,
  output logic [WIDTH+ACC_PAD-1:0] c_next
);

  localparam int ACC_W = WIDTH + ACC_PAD;

  logic [ACC_W-1:0] sum_b;
  logic [ACC_W-1:0] sum_m;

  always_comb begin
    sum_b  = c + (a_i ? {{ACC_PAD{1'b0}}, b} : '0);
    // Adding odd M to an odd sum makes it even, so the shift is exact.
    sum_m  = sum_b[0] ? sum_b + {{ACC_PAD{1'b0}}, m} : sum_b;
    c_next = sum_m >> 1;
  end

endmodule

// File: rtl/montgomery_mul_serial.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M, start/done handshake.
// Optional macro MONT_2BIT_EN chains two steps per cycle (WIDTH must be even).
module montgomery_mul_serial
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int ACC_W = WIDTH + ACC_PAD;
`ifdef MONT_2BIT_EN
  localparam int BPC = 2;
`else
  localparam int BPC = 1;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - BPC);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_q, m_q;
  logic [ACC_W-1:0] c_q, c_step;
  logic [CNT_W-1:0] cnt;
  logic             c_ge_m;
  logic [WIDTH-1:0] c_red;

  // Multiplier bits are consumed LSB-first from a shifting copy of A.
`ifdef MONT_2BIT_EN
  logic [ACC_W-1:0] c_mid;

  mont_step #(.WIDTH(WIDTH)) u_step0 (
    .c(c_q), .a_i(a_sh[0]), .b(b_q), .m(m_q), .c_next(c_mid)
  );
  mont_step #(.WIDTH(WIDTH)) u_step1 (
    .c(c_mid), .a_i(a_sh[1]), .b(b_q), .m(m_q), .c_next(c_step)
  );
`else
  mont_step #(.WIDTH(WIDTH)) u_step0 (
    .c(c_q), .a_i(a_sh[0]), .b(b_q), .m(m_q), .c_next(c_step)
  );
`endif

  // C < 2M, so C - M fits in WIDTH bits; modular WIDTH-bit subtract is exact.
  assign c_ge_m = c_q >= {{ACC_PAD{1'b0}}, m_q};
  assign c_red  = c_ge_m ? (c_q[WIDTH-1:0] - m_q) : c_q[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (cnt == LAST) state_nxt = SUB;
      SUB:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == SUB);
      case (state)
        IDLE: if (start) begin
          a_sh <= in_a;
          b_q  <= in_b;
          m_q  <= in_m;
          c_q  <= '0;
          cnt  <= '0;
        end
        ITER: begin
          c_q  <= c_step;
          a_sh <= a_sh >> BPC;
          cnt  <= cnt + CNT_W'(BPC);
        end
        SUB:     result <= c_red;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mul_serial.sv
// Scoreboard bench: WIDTH=8 instance for handshake/latency corners, WIDTH=512 for random vectors.
module tb_montgomery_mul_serial;

  localparam int W8 = 8;
  localparam int WB = 512;
`ifdef MONT_2BIT_EN
  localparam int BPC = 2;
`else
  localparam int BPC = 1;
`endif
  localparam int LAT8 = W8 / BPC + 2;
  localparam int LATB = WB / BPC + 2;

  typedef struct {
    logic [WB-1:0] val;
    int            at;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start8, startb;
  logic [W8-1:0] a8, b8, m8, r8;
  logic [WB-1:0] ab, bb, mb, rb;
  logic          done8, doneb;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q8[$];
  exp_t qb[$];
  exp_t e8, eb;

  montgomery_mul_serial #(.WIDTH(W8), .CNT_W(4)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8),
    .in_a(a8), .in_b(b8), .in_m(m8), .result(r8), .done(done8)
  );

  montgomery_mul_serial #(.WIDTH(WB), .CNT_W(10)) dutb (
    .clk(clk), .resetn(resetn), .start(startb),
    .in_a(ab), .in_b(bb), .in_m(mb), .result(rb), .done(doneb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  // Reference: reduce A*B mod M, then divide by 2 mod M once per bit of R.
  function automatic logic [WB-1:0] mref(input logic [WB-1:0] a, input logic [WB-1:0] b,
                                         input logic [WB-1:0] m, input int w);
    logic [WB:0] x;
    x = (WB+1)'(({{WB{1'b0}}, a} * {{WB{1'b0}}, b}) % {{WB{1'b0}}, m});
    for (int i = 0; i < w; i++)
      x = x[0] ? ((x + {1'b0, m}) >> 1) : (x >> 1);
    return x[WB-1:0];
  endfunction

  function automatic logic [WB-1:0] rnd512();
    logic [WB-1:0] r;
    for (int i = 0; i < WB / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Monitors: every done must match the head of the queue in value and cycle.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL done8_unexpected cyc=%0d", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("res8", WB'(r8), e8.val);
        chk("lat8", WB'(cyc), WB'(e8.at));
      end
    end
    if (doneb) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL doneb_unexpected cyc=%0d", cyc);
      end else begin
        eb = qb.pop_front();
        chk("resb", rb, eb.val);
        chk("latb", WB'(cyc), WB'(eb.at));
      end
    end
  end

  // Called at a negedge; start is high for exactly the cycle k returned.
  task automatic go8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic [W8-1:0] m,
                     input logic [W8-1:0] ev, input bit push, output int k);
    exp_t e;
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    k = cyc;
    if (push) begin
      e.val = WB'(ev);
      e.at  = k + LAT8;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom()); b8 = 8'($urandom()); m8 = 8'($urandom());
  endtask

  task automatic gob(input logic [WB-1:0] a, input logic [WB-1:0] b, input logic [WB-1:0] m,
                     input logic [WB-1:0] ev);
    exp_t e;
    ab = a; bb = b; mb = m; startb = 1'b1;
    e.val = ev;
    e.at  = cyc + LATB;
    qb.push_back(e);
    @(negedge clk);
    startb = 1'b0;
    ab = rnd512(); bb = rnd512(); mb = rnd512();
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < LAT8 + 20) begin @(negedge clk); n++; end
    if (q8.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout8 cyc=%0d pending=%0d", cyc, q8.size());
      q8.delete();
    end
  endtask

  task automatic drainb();
    int n = 0;
    while (qb.size() != 0 && n < LATB + 20) begin @(negedge clk); n++; end
    if (qb.size() != 0) begin
      total++; bad++;
      $display("FAIL timeoutb cyc=%0d pending=%0d", cyc, qb.size());
      qb.delete();
    end
  endtask

  initial begin
    int            k;
    logic [W8-1:0] m, a, b;
    logic [WB-1:0] mw, aw, bw, yw, r2;
    logic [2*WB:0] big;

    start8 = 1'b0; startb = 1'b0;
    a8 = '0; b8 = '0; m8 = '0;
    ab = '0; bb = '0; mb = '0;
    repeat (3) @(negedge clk);
    chk("rst_done8", WB'(done8), '0);
    chk("rst_res8", WB'(r8), '0);
    chk("rst_doneb", WB'(doneb), '0);
    chk("rst_resb", rb, '0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived results for M=181 (R mod M = 75, R^-1 = 70).
    go8(8'd1,   8'd75,  8'd181, 8'd1,   1'b1, k); drain8();
    go8(8'd180, 8'd1,   8'd181, 8'd111, 1'b1, k); drain8();
    go8(8'd75,  8'd75,  8'd181, 8'd75,  1'b1, k); drain8();
    go8(8'd0,   8'd100, 8'd181, 8'd0,   1'b1, k); drain8();
    go8(8'd100, 8'd0,   8'd181, 8'd0,   1'b1, k); drain8();
    repeat (3) @(negedge clk);
    chk("hold8", WB'(r8), '0);

    for (int i = 0; i < 20; i++) begin
      m = 8'($urandom()) | 8'h81;
      a = 8'($urandom() % m);
      b = 8'($urandom() % m);
      go8(a, b, m, 8'(mref(WB'(a), WB'(b), WB'(m), W8)), 1'b1, k);
      drain8();
    end

    // start held through DONE: only the first one is accepted.
    a8 = 8'd1; b8 = 8'd75; m8 = 8'd181; start8 = 1'b1;
    k = cyc;
    e8.val = WB'(8'd1); e8.at = k + LAT8;
    q8.push_back(e8);
    while (cyc < k + LAT8) @(negedge clk);
    @(negedge clk);
    start8 = 1'b0;
    drain8();
    repeat (LAT8 + 5) @(negedge clk);

    // Back-to-back: second start in the cycle right after done.
    go8(8'd75, 8'd75, 8'd181, 8'd75, 1'b1, k);
    while (cyc < k + LAT8 + 1) @(negedge clk);
    go8(8'd180, 8'd1, 8'd181, 8'd111, 1'b1, k);
    drain8();
    repeat (3) @(negedge clk);
    chk("hold8b", WB'(r8), WB'(8'd111));

    // Reset mid-ITER aborts without done; a fresh run afterwards is nominal.
    go8(8'd75, 8'd75, 8'd181, 8'd0, 1'b0, k);
    while (cyc < k + 5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_done8", WB'(done8), '0);
    chk("abort_res8", WB'(r8), '0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (LAT8 + 3) @(negedge clk);
    chk("abort_res8_idle", WB'(r8), '0);
    go8(8'd180, 8'd1, 8'd181, 8'd111, 1'b1, k);
    drain8();
    repeat (5) @(negedge clk);

    // Wide random vectors.
    for (int i = 0; i < 30; i++) begin
      mw = rnd512(); mw[0] = 1'b1; mw[WB-1] = 1'b1;
      aw = rnd512() % mw;
      bw = rnd512() % mw;
      gob(aw, bw, mw, mref(aw, bw, mw, WB));
      drainb();
    end

    // Into and out of the Montgomery domain returns the original value.
    for (int i = 0; i < 3; i++) begin
      mw = rnd512(); mw[0] = 1'b1; mw[WB-1] = 1'b1;
      aw = rnd512() % mw;
      big = '0; big[2*WB] = 1'b1;
      r2 = WB'(big % {{(WB+1){1'b0}}, mw});
      yw = mref(aw, r2, mw, WB);
      gob(aw, r2, mw, yw);
      drainb();
      gob(yw, WB'(1), mw, aw);
      drainb();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
